// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI coherence bus controller: arbitration, snoop, cache-to-cache or RAM completion.
// Optional: define COHERENCE_ROUND_ROBIN_EN for round-robin arbitration (default is fixed priority to core 0).

package msi_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BUSRD      = 3'd1,
    BUSRDX     = 3'd2,
    INVALIDATE = 3'd3,
    WB         = 3'd4
  } bus_command;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_C2C   = 3'd2,
    ST_MEMRD = 3'd3,
    ST_MEMWB = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_t;
endpackage

// Handshakes: req_cmd is held by the requester until its done pulse; snoop_valid
// stays high until snoop_ack from that core (same cycle allowed); ram_ren/ram_wen
// stay high until ram_ready, and the access completes in the ram_ready cycle.
module coherence_bus_ctrl
  import msi_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  bus_command  req_cmd [2],
  input  word_t       req_addr [2],
  input  word_t       req_wdata [2],
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output word_t       rdata,
  output logic [1:0]  snoop_valid,
  output bus_command  snoop_cmd,
  output word_t       snoop_addr,
  input  logic [1:0]  snoop_ack,
  input  logic [1:0]  snoop_dirty,
  input  word_t       snoop_data [2],
  output logic        ram_ren,
  output logic        ram_wen,
  output word_t       ram_addr,
  output word_t       ram_wdata,
  input  word_t       ram_rdata,
  input  logic        ram_ready,
  output ctrl_state_t state_dbg
);

  ctrl_state_t state_q, state_d;
  logic        id_q;
  logic        other;
  logic        win;
  logic [1:0]  req_any;
  bus_command  cmd_q;
  word_t       addr_q;
  word_t       wdata_q;
  word_t       data_q;
  logic [1:0]  grant_q;

  assign other     = ~id_q;
  assign state_dbg = state_q;
  assign grant     = grant_q;

  always_comb begin
    req_any[0] = (req_cmd[0] != IDLE);
    req_any[1] = (req_cmd[1] != IDLE);
  end

`ifdef COHERENCE_ROUND_ROBIN_EN
  // prio_q names the core that wins a tie: the one not served last.
  logic prio_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      prio_q <= ~id_q;
    end
  end

  assign win = (req_any == 2'b11) ? prio_q : ~req_any[0];
`else
  assign win = ~req_any[0];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      id_q    <= 1'b0;
      cmd_q   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (|req_any) begin
            id_q         <= win;
            cmd_q        <= req_cmd[win];
            addr_q       <= req_addr[win];
            wdata_q      <= req_wdata[win];
            data_q       <= '0;
            grant_q[win] <= 1'b1;
          end
        end
        ST_SNOOP: begin
          // An invalidate never returns data, even if the snooped line was dirty.
          if (snoop_ack[other] && snoop_dirty[other] && (cmd_q != INVALIDATE)) begin
            data_q <= snoop_data[other];
          end
        end
        ST_MEMRD: begin
          if (ram_ready) begin
            data_q <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_any) begin
          state_d = (req_cmd[win] == WB) ? ST_MEMWB : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (snoop_ack[other]) begin
          if (cmd_q == INVALIDATE) begin
            state_d = ST_DONE;
          end else if (snoop_dirty[other]) begin
            state_d = ST_C2C;
          end else begin
            state_d = ST_MEMRD;
          end
        end
      end
      ST_C2C, ST_MEMRD, ST_MEMWB: begin
        if (ram_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done        = 2'b00;
    rdata       = '0;
    snoop_valid = 2'b00;
    snoop_cmd   = IDLE;
    snoop_addr  = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (state_q)
      ST_SNOOP: begin
        snoop_valid[other] = 1'b1;
        snoop_cmd          = cmd_q;
        snoop_addr         = addr_q;
      end
      ST_C2C: begin
        // Dirty line is written back to RAM while it is forwarded to the requester.
        ram_wen   = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = data_q;
      end
      ST_MEMRD: begin
        ram_ren  = 1'b1;
        ram_addr = addr_q;
      end
      ST_MEMWB: begin
        ram_wen   = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
      end
      ST_DONE: begin
        done[id_q] = 1'b1;
        rdata      = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: vector table, arbitration/reset sequences, random
// transactions against a latency/data model derived from the bus protocol rules.
module tb_coherence_bus_ctrl;
  import msi_pkg::*;

`ifdef COHERENCE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  bus_command  req_cmd [2];
  word_t       req_addr [2];
  word_t       req_wdata [2];
  logic [1:0]  grant, done, snoop_valid;
  word_t       rdata, snoop_addr, ram_addr, ram_wdata;
  bus_command  snoop_cmd;
  logic [1:0]  snoop_ack, snoop_dirty;
  word_t       snoop_data [2];
  logic        ram_ren, ram_wen, ram_ready;
  word_t       ram_rdata;
  ctrl_state_t state_dbg;

  coherence_bus_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_ack(snoop_ack), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int last_srv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RAM initial contents; 0x100 is preloaded for the first vector.
  function automatic word_t mem_init(input word_t a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // ---------------- responders / monitor ----------------
  int    cfg_sw = 0, cfg_rw = 0;
  bit    cfg_dirty = 1'b0;
  bus_command exp_scmd = IDLE;
  word_t exp_saddr = '0;
  word_t ram_mem [word_t];
  int    snp_cyc [2] = '{0, 0};
  int    ren_cyc = 0, wen_cyc = 0, snp_bad = 0, addr_bad = 0, both_bad = 0;
  word_t last_waddr = '0, last_wdata = '0;

  initial begin
    int scnt = 0;
    int rcnt = 0;
    snoop_ack = 2'b00; snoop_dirty = 2'b00; ram_ready = 1'b0; ram_rdata = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        snoop_ack = 2'b00; snoop_dirty = 2'b00; ram_ready = 1'b0; scnt = 0; rcnt = 0;
      end else begin
        if (snoop_valid != 2'b00) begin
          if (snoop_valid[0]) snp_cyc[0]++;
          if (snoop_valid[1]) snp_cyc[1]++;
          if (snoop_cmd !== exp_scmd || snoop_addr !== exp_saddr) snp_bad++;
          if (scnt >= cfg_sw) begin
            snoop_ack = snoop_valid;
            snoop_dirty = cfg_dirty ? snoop_valid : 2'b00;
            scnt = 0;
          end else begin
            snoop_ack = 2'b00; snoop_dirty = 2'b00; scnt++;
          end
        end else begin
          snoop_ack = 2'b00; snoop_dirty = 2'b00; scnt = 0;
        end
        if (ram_ren || ram_wen) begin
          if (ram_ren && ram_wen) both_bad++;
          if (ram_ren) ren_cyc++;
          if (ram_wen) wen_cyc++;
          if (ram_addr !== exp_saddr) addr_bad++;
          if (rcnt >= cfg_rw) begin
            ram_ready = 1'b1;
            rcnt = 0;
            ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : mem_init(ram_addr);
            if (ram_wen) begin
              ram_mem[ram_addr] = ram_wdata;
              last_waddr = ram_addr;
              last_wdata = ram_wdata;
            end
          end else begin
            ram_ready = 1'b0; ram_rdata = 32'hBAD0BAD0; rcnt++;
          end
        end else begin
          ram_ready = 1'b0; ram_rdata = 32'hBAD0BAD0; rcnt = 0;
        end
      end
    end
  end

  function automatic logic [31:0] outs_zero();
    return 32'((grant == 2'b00) && (done == 2'b00) && (rdata == '0) &&
               (snoop_valid == 2'b00) && (snoop_cmd == IDLE) && (snoop_addr == '0) &&
               !ram_ren && !ram_wen && (ram_addr == '0) && (ram_wdata == '0));
  endfunction

  // ---------------- driver: one transaction with full checking ----------------
  task automatic run_check(input string tag, input int core, input bus_command cmd,
                           input word_t addr, input word_t wdata, input int sw, input int rw,
                           input bit dirty, input word_t sdata, input int e_lat,
                           input word_t e_rd, input int e_ren, input int e_wen, input int e_snp);
    int b_ren, b_wen, b_so, b_ss, b_sb, b_ab, b_bb, t0, lat, glat;
    word_t got;
    bit ok;
    @(negedge CLK);
    cfg_sw = sw; cfg_rw = rw; cfg_dirty = dirty;
    snoop_data[0] = sdata; snoop_data[1] = sdata;
    exp_scmd = cmd; exp_saddr = addr;
    b_ren = ren_cyc; b_wen = wen_cyc; b_so = snp_cyc[1-core]; b_ss = snp_cyc[core];
    b_sb = snp_bad; b_ab = addr_bad; b_bb = both_bad;
    req_cmd[core] = cmd; req_addr[core] = addr; req_wdata[core] = wdata;
    t0 = cyc; ok = 1'b0; lat = -1; glat = -1; got = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (grant[core] && glat < 0) glat = cyc - t0;
      if (done[core]) begin
        lat = cyc - t0; got = rdata; ok = 1'b1;
        break;
      end
    end
    req_cmd[core] = IDLE;
    if (ok) last_srv = core;
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_grant_lat"}, glat, 32'd1);
    chk({tag, "_done_lat"}, lat, e_lat);
    chk({tag, "_rdata"}, got, e_rd);
    chk({tag, "_ren_cycles"}, ren_cyc - b_ren, e_ren);
    chk({tag, "_wen_cycles"}, wen_cyc - b_wen, e_wen);
    chk({tag, "_snoop_other"}, snp_cyc[1-core] - b_so, e_snp);
    chk({tag, "_snoop_self"}, snp_cyc[core] - b_ss, 32'd0);
    chk({tag, "_snoop_fields"}, snp_bad - b_sb, 32'd0);
    chk({tag, "_ram_addr"}, addr_bad - b_ab, 32'd0);
    chk({tag, "_ren_wen_excl"}, both_bad - b_bb, 32'd0);
    if (e_wen > 0) begin
      chk({tag, "_wr_addr"}, last_waddr, addr);
      chk({tag, "_wr_data"}, last_wdata, (cmd == WB) ? wdata : sdata);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int core; bus_command cmd; word_t addr; word_t wdata;
    int sw; int rw; bit dirty; word_t sdata;
    int lat; word_t rd; int ren; int wen; int snp;
  } vec_t;
  vec_t vecs [7];

  // ---------------- behavioural reference model ----------------
  word_t ref_mem [word_t];

  function automatic word_t ref_read(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  initial begin
    int left [2];
    int left_m [2];
    bit reraise [2];
    int lm, w;
    logic [31:0] e;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_cmd[i] = IDLE; req_addr[i] = '0; req_wdata[i] = '0; snoop_data[i] = '0;
    end
    repeat (2) @(negedge CLK);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("reset_outputs_zero", outs_zero(), 32'd1);
    RST = 1'b0;
    last_srv = 1;

    // core, cmd, addr, wdata, sw, rw, dirty, sdata, lat, rdata, ren, wen, snoop
    vecs[0] = '{0, BUSRD,      32'h100, 32'h0,        0, 2, 1'b0, 32'h0,        5, 32'hDEADBEEF, 3, 0, 1};
    vecs[1] = '{1, BUSRDX,     32'h200, 32'h0,        0, 0, 1'b1, 32'hCAFEF00D, 3, 32'hCAFEF00D, 0, 1, 1};
    vecs[2] = '{0, INVALIDATE, 32'h300, 32'h0,        0, 0, 1'b0, 32'h0,        2, 32'h0,        0, 0, 1};
    vecs[3] = '{1, WB,         32'h400, 32'h12345678, 0, 2, 1'b0, 32'h0,        4, 32'h0,        0, 3, 0};
    vecs[4] = '{0, BUSRD,      32'h200, 32'h0,        2, 1, 1'b0, 32'h0,        6, 32'hCAFEF00D, 2, 0, 3};
    vecs[5] = '{1, BUSRD,      32'h400, 32'h0,        1, 0, 1'b0, 32'h0,        4, 32'h12345678, 1, 0, 2};
    vecs[6] = '{0, INVALIDATE, 32'h300, 32'h0,        3, 0, 1'b1, 32'h55AA55AA, 5, 32'h0,        0, 0, 4};
    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].core, vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                vecs[i].sw, vecs[i].rw, vecs[i].dirty, vecs[i].sdata,
                vecs[i].lat, vecs[i].rd, vecs[i].ren, vecs[i].wen, vecs[i].snp);
    end

    // Simultaneous requests; core 0 re-requests as soon as it is served once.
    left_m[0] = 2; left_m[1] = 1; lm = last_srv;
    while (left_m[0] + left_m[1] > 0) begin
      if (left_m[0] > 0 && left_m[1] > 0) w = RR ? 1 - lm : 0;
      else w = (left_m[0] > 0) ? 0 : 1;
      exp_q.push_back(32'(w));
      left_m[w]--; lm = w;
    end
    cfg_sw = 0; cfg_rw = 0; cfg_dirty = 1'b0;
    left[0] = 2; left[1] = 1; reraise[0] = 1'b0; reraise[1] = 1'b0;
    @(negedge CLK);
    req_cmd[0] = BUSRD; req_addr[0] = 32'h1200;
    req_cmd[1] = BUSRD; req_addr[1] = 32'h1204;
    for (int k = 0; k < 200 && (left[0] + left[1]) > 0; k++) begin
      @(negedge CLK);
      for (int c = 0; c < 2; c++) begin
        if (done[c]) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk("arb_order", 32'(c), e);
          last_srv = c; left[c]--; req_cmd[c] = IDLE; reraise[c] = (left[c] > 0);
        end else if (reraise[c]) begin
          req_cmd[c] = BUSRD; reraise[c] = 1'b0;
        end
      end
    end
    req_cmd[0] = IDLE; req_cmd[1] = IDLE;
    chk("arb_all_served", 32'(left[0] + left[1]), 32'd0);
    chk("arb_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a RAM read.
    @(negedge CLK);
    cfg_sw = 0; cfg_rw = 20; cfg_dirty = 1'b0; exp_scmd = BUSRD; exp_saddr = 32'h1100;
    req_cmd[0] = BUSRD; req_addr[0] = 32'h1100;
    for (int k = 0; k < 20 && !ram_ren; k++) @(negedge CLK);
    chk("rst_mid_reached_memrd", 32'(ram_ren), 32'd1);
    RST = 1'b1; req_cmd[0] = IDLE;
    @(negedge CLK);
    chk("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_mid_outputs_zero", outs_zero(), 32'd1);
    RST = 1'b0; last_srv = 1; cfg_rw = 0;
    run_check("post_rst", 1, BUSRD, 32'h1104, 32'h0, 0, 1, 1'b0, 32'h0,
              4, ref_read(32'h1104), 2, 0, 1);

    // Random single transactions against the model.
    for (int i = 0; i < 40; i++) begin
      int core, sw, rw, e_lat, e_ren, e_wen, e_snp;
      bus_command cmd;
      word_t addr, wdata, sdata, e_rd;
      bit dirty, is_rd;
      core  = $urandom_range(0, 1);
      cmd   = bus_command'(3'($urandom_range(1, 4)));
      addr  = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
      wdata = $urandom; sdata = $urandom;
      sw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      dirty = 1'($urandom_range(0, 1));
      is_rd = (cmd == BUSRD) || (cmd == BUSRDX);
      e_lat = (cmd == INVALIDATE) ? 2 + sw : (cmd == WB) ? 2 + rw : 3 + sw + rw;
      e_rd  = !is_rd ? 32'h0 : dirty ? sdata : ref_read(addr);
      e_ren = (is_rd && !dirty) ? rw + 1 : 0;
      e_wen = ((cmd == WB) || (is_rd && dirty)) ? rw + 1 : 0;
      e_snp = (cmd == WB) ? 0 : sw + 1;
      run_check($sformatf("rnd%0d", i), core, cmd, addr, wdata, sw, rw, dirty, sdata,
                e_lat, e_rd, e_ren, e_wen, e_snp);
      if (cmd == WB) ref_mem[addr] = wdata;
      else if (is_rd && dirty) ref_mem[addr] = sdata;
    end

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
